// File: rtl/bus_codes_pkg.sv
// bus_codes_pkg: bus source/destination code map and transfer sequencer states.
package bus_codes_pkg;
   localparam logic [4:0] CODE_R0     = 5'd0;
   localparam logic [4:0] CODE_R1     = 5'd1;
   localparam logic [4:0] CODE_R2     = 5'd2;
   localparam logic [4:0] CODE_R3     = 5'd3;
   localparam logic [4:0] CODE_R4     = 5'd4;
   localparam logic [4:0] CODE_R5     = 5'd5;
   localparam logic [4:0] CODE_R6     = 5'd6;
   localparam logic [4:0] CODE_R7     = 5'd7;
   localparam logic [4:0] CODE_R8     = 5'd8;
   localparam logic [4:0] CODE_R9     = 5'd9;
   localparam logic [4:0] CODE_R10    = 5'd10;
   localparam logic [4:0] CODE_R11    = 5'd11;
   localparam logic [4:0] CODE_R12    = 5'd12;
   localparam logic [4:0] CODE_R13    = 5'd13;
   localparam logic [4:0] CODE_R14    = 5'd14;
   localparam logic [4:0] CODE_R15    = 5'd15;
   localparam logic [4:0] CODE_HI     = 5'd16;
   localparam logic [4:0] CODE_LO     = 5'd17;
   localparam logic [4:0] CODE_ZHI    = 5'd18;
   localparam logic [4:0] CODE_ZLO    = 5'd19;
   localparam logic [4:0] CODE_PC     = 5'd20;
   localparam logic [4:0] CODE_MDR    = 5'd21;
   localparam logic [4:0] CODE_INPORT = 5'd22;
   localparam logic [4:0] CODE_COUT   = 5'd23;
   localparam logic [4:0] CODE_RSVD_MIN = 5'd24;

   typedef enum logic [2:0] {IDLE, DRIVE, LOAD, DONE, ERR} state_e;

   function automatic logic is_rsvd(input logic [4:0] code);
      return code >= CODE_RSVD_MIN;
   endfunction
endpackage

// File: rtl/onehot_decoder_5to32.sv
// onehot_decoder_5to32: code to one-hot strobe; reserved codes decode to zero unless en is high.
module onehot_decoder_5to32
   import bus_codes_pkg::*;
(
   input  logic [4:0]  code,
   input  logic        en,
   output logic [31:0] onehot
);
   assign onehot = (en || !is_rsvd(code)) ? 32'd1 << code : '0;
endmodule

// File: rtl/bus_transfer_decoder.sv
// bus_transfer_decoder: sequences one bus transfer per request (drive, settle, load, done)
// and emits registered one-hot drive/load strobes.
module bus_transfer_decoder
   import bus_codes_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int CODE_W        = 5
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              req_IN,
   input  logic [CODE_W-1:0] src_code_IN,
   input  logic [CODE_W-1:0] dst_code_IN,
   input  logic              load_en_IN,
   output logic              ready_OUT,
   output logic [31:0]       bus_drive_OUT,
   output logic [31:0]       reg_load_OUT,
   output logic              busy_OUT,
   output logic              done_OUT,
   output logic              err_OUT
);
   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [4:0]  src_q, src_d, dst_q, dst_d;
   logic        ld_q, ld_d;
   logic [31:0] drive_q, drive_d, load_q, load_d;
   logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [4:0]  src_sel, dst_sel;
   logic [31:0] src_oh, dst_oh;

   // In IDLE decode the live inputs so the first drive cycle follows the accept edge directly.
   assign src_sel = (state_q == IDLE) ? src_code_IN : src_q;
   assign dst_sel = (state_q == IDLE) ? dst_code_IN : dst_q;

   onehot_decoder_5to32 u_src_dec (.code(src_sel), .en(1'b0), .onehot(src_oh));
   onehot_decoder_5to32 u_dst_dec (.code(dst_sel), .en(1'b0), .onehot(dst_oh));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      src_d   = src_q;
      dst_d   = dst_q;
      ld_d    = ld_q;
      drive_d = '0;
      load_d  = '0;
      case (state_q)
         IDLE: if (req_IN) begin
            src_d = src_code_IN;
            dst_d = dst_code_IN;
            ld_d  = load_en_IN;
            if (is_rsvd(src_code_IN) || (load_en_IN && is_rsvd(dst_code_IN))) begin
               state_d = ERR;
            end else begin
               state_d = DRIVE;
               drive_d = src_oh;
               cnt_d   = 4'(SETTLE_CYCLES - 1);
            end
         end
         DRIVE: if (cnt_q == '0) begin
            state_d = ld_q ? LOAD : DONE;
            drive_d = ld_q ? src_oh : '0;
            load_d  = ld_q ? dst_oh : '0;
         end else begin
            cnt_d   = cnt_q - 4'd1;
            drive_d = src_oh;
         end
         LOAD:    state_d = DONE;
         default: state_d = IDLE;
      endcase
      busy_d = state_d inside {DRIVE, LOAD, DONE};
      done_d = state_d == DONE;
      err_d  = state_d == ERR;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         ld_q    <= 1'b0;
         drive_q <= '0;
         load_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         ld_q    <= ld_d;
         drive_q <= drive_d;
         load_q  <= load_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign ready_OUT     = state_q == IDLE;
   assign bus_drive_OUT = drive_q;
   assign reg_load_OUT  = load_q;
   assign busy_OUT      = busy_q;
   assign done_OUT      = done_q;
   assign err_OUT       = err_q;
endmodule
